// File: rtl/pipe_ctrl_if.sv
// Stall/flush controller bundle: hazard requests and exception redirect in, stall vector and stats out.
// Ports: stallreq_id/ex/mem, excp_req, excp_pc (requests); stall, flush, new_pc, stall_timeout, stall_cnt, flush_cnt (results).
// master = pipeline side driving requests; slave = controller side driving results.
interface pipe_ctrl_if #(
    parameter int unsigned CNT_W = 32
);
    logic             stallreq_id;
    logic             stallreq_ex;
    logic             stallreq_mem;
    logic             excp_req;
    logic [31:0]      excp_pc;
    logic [5:0]       stall;
    logic             flush;
    logic [31:0]      new_pc;
    logic             stall_timeout;
    logic [CNT_W-1:0] stall_cnt;
    logic [15:0]      flush_cnt;

    modport master (
        output stallreq_id, stallreq_ex, stallreq_mem, excp_req, excp_pc,
        input  stall, flush, new_pc, stall_timeout, stall_cnt, flush_cnt
    );

    modport slave (
        input  stallreq_id, stallreq_ex, stallreq_mem, excp_req, excp_pc,
        output stall, flush, new_pc, stall_timeout, stall_cnt, flush_cnt
    );
endinterface

// File: rtl/pipe_ctrl.sv
// Pipeline stall/flush controller: prioritised per-stage stall vector, exception flush FSM, stats and stall watchdog.
// Latency: stall/flush/new_pc are combinational (0 cycles); counters and watchdog flag update one cycle later.
// Backpressure: requesters hold their request until satisfied; a flush overrides all stalls and is followed by one DRAIN cycle.
// Ports: clk, rst (synchronous, active-high), bus (pipe_ctrl_if.slave).
module pipe_ctrl #(
    parameter int unsigned STALL_LIMIT = 1023,
    parameter int unsigned CNT_W       = 32
) (
    input  logic        clk,
    input  logic        rst,
    pipe_ctrl_if.slave  bus
);
    typedef enum logic {
        RUN   = 1'b0,
        DRAIN = 1'b1
    } state_t;

    localparam logic [15:0] LIMIT = 16'(STALL_LIMIT);

    state_t           state_q;
    logic [15:0]      run_len_q;
    logic             timeout_q;
    logic [CNT_W-1:0] stall_cnt_q;
    logic [15:0]      flush_cnt_q;

    logic [5:0]       stall_w;
    logic             flush_w;
    logic [31:0]      new_pc_w;

    // Outputs are forced quiet during reset and in DRAIN, where the
    // exception source has just been flushed and must not re-trigger.
    always_comb begin
        stall_w  = 6'b000000;
        flush_w  = 1'b0;
        new_pc_w = 32'h0;
        if (!rst && state_q == RUN) begin
            if (bus.excp_req) begin
                flush_w  = 1'b1;
                new_pc_w = bus.excp_pc;
            end else if (bus.stallreq_mem) begin
                stall_w = 6'b011111;
            end else if (bus.stallreq_ex) begin
                stall_w = 6'b001111;
            end else if (bus.stallreq_id) begin
                stall_w = 6'b000111;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= RUN;
            run_len_q   <= 16'h0;
            timeout_q   <= 1'b0;
            stall_cnt_q <= '0;
            flush_cnt_q <= 16'h0;
        end else begin
            // DRAIN always lasts one cycle; a flush can only occur in RUN.
            state_q <= flush_w ? DRAIN : RUN;

            // run_len stops at LIMIT; a further stalled cycle there trips the sticky flag.
            if (|stall_w) begin
                if (run_len_q != LIMIT) begin
                    run_len_q <= run_len_q + 16'd1;
                end else begin
                    timeout_q <= 1'b1;
                end
            end else begin
                run_len_q <= 16'h0;
            end

            if (|stall_w && stall_cnt_q != {CNT_W{1'b1}}) begin
                stall_cnt_q <= stall_cnt_q + 1'b1;
            end

            if (flush_w && flush_cnt_q != 16'hFFFF) begin
                flush_cnt_q <= flush_cnt_q + 16'd1;
            end
        end
    end

    assign bus.stall         = stall_w;
    assign bus.flush         = flush_w;
    assign bus.new_pc        = new_pc_w;
    assign bus.stall_timeout = timeout_q;
    assign bus.stall_cnt     = stall_cnt_q;
    assign bus.flush_cnt     = flush_cnt_q;
endmodule
